// File: rtl/ifu.sv
// Instruction fetch unit for the NPC core.
// Holds the architectural PC, fetches one instruction per commit over a
// valid/ready request and single-cycle response handshake, and presents the
// word to the decoder until commit supplies the next PC. Misaligned PCs, bus
// errors and response timeouts are presented as a fault slot with inst = 0.
module ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned CNT_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_update,
  input  logic [31:0] pc_next,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        inst_fault,
  output logic [31:0] fetch_cnt
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_VALID,
    S_FAULT
  } state_t;

  // Timeout fires on the last allowed wait cycle; a zero TIMEOUT disables it.
  localparam bit              TO_EN    = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_hit;
  logic             next_misaligned;
  logic             req_fire;

  assign imem_addr       = pc;
  assign req_fire        = imem_req_valid && imem_req_ready;
  assign timeout_hit     = TO_EN && (wait_cnt == CNT_LAST);
  assign next_misaligned = (pc_next[1:0] != 2'b00);

  // Fetch sequencer: all outputs are registered and updated alongside the state.
  // The request valid is a register so it stays low while reset is held and
  // rises on the first clock after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_REQ;
      pc             <= RESET_PC;
      inst           <= '0;
      inst_valid     <= 1'b0;
      inst_fault     <= 1'b0;
      fetch_cnt      <= '0;
      wait_cnt       <= '0;
      imem_req_valid <= 1'b0;
    end else begin
      case (state)
        S_REQ: begin
          if (req_fire) begin
            imem_req_valid <= 1'b0;
            wait_cnt       <= '0;
            state          <= S_WAIT;
          end else begin
            imem_req_valid <= 1'b1;
          end
        end

        S_WAIT: begin
          if (imem_rsp_valid) begin
            inst_valid <= 1'b1;
            if (imem_rsp_err) begin
              inst       <= '0;
              inst_fault <= 1'b1;
              state      <= S_FAULT;
            end else begin
              inst       <= imem_rsp_data;
              inst_fault <= 1'b0;
              fetch_cnt  <= fetch_cnt + 32'd1;
              state      <= S_VALID;
            end
          end else if (timeout_hit) begin
            inst       <= '0;
            inst_valid <= 1'b1;
            inst_fault <= 1'b1;
            state      <= S_FAULT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        S_VALID, S_FAULT: begin
          if (pc_update) begin
            pc <= pc_next;
            if (next_misaligned) begin
              inst       <= '0;
              inst_valid <= 1'b1;
              inst_fault <= 1'b1;
              state      <= S_FAULT;
            end else begin
              inst_valid     <= 1'b0;
              inst_fault     <= 1'b0;
              imem_req_valid <= 1'b1;
              state          <= S_REQ;
            end
          end
        end

        default: begin
          state <= S_REQ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifu.sv
// Directed testbench for ifu with a scoreboard: each fetch or fault pushes the
// slot the decoder should see, and a monitor pops and compares every newly
// presented slot. Direct checks cover handshake timing and reset behaviour.
module tb_ifu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_update = 1'b0;
  logic [31:0] pc_next = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        imem_rsp_err = 1'b0;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_fault;
  logic [31:0] fetch_cnt;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
    logic [31:0] cnt;
  } slot_t;

  slot_t       exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_cnt = '0;

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  ifu #(
    .RESET_PC(32'h8000_0000),
    .TIMEOUT (3),
    .CNT_W   (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_update     (pc_update),
    .pc_next       (pc_next),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_addr     (imem_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .imem_rsp_err  (imem_rsp_err),
    .pc            (pc),
    .inst          (inst),
    .inst_valid    (inst_valid),
    .inst_fault    (inst_fault),
    .fetch_cnt     (fetch_cnt)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_slot(input logic [31:0] a, input logic [31:0] d, input logic f, input logic [31:0] c);
    slot_t s;
    s.pc    = a;
    s.inst  = d;
    s.fault = f;
    s.cnt   = c;
    exp_q.push_back(s);
  endtask

  // A slot is new when inst_valid rises or when a commit was taken while a
  // slot was already presented (fault-to-fault or valid-to-fault redirect).
  task automatic monitor();
    logic  prev_valid = 1'b0;
    logic  upd_pend = 1'b0;
    slot_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0;
        upd_pend   = 1'b0;
      end else begin
        if (inst_valid && (!prev_valid || upd_pend)) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unexpected slot: got pc 0x%08h, required no slot", pc);
          end else begin
            e = exp_q.pop_front();
            check_output("slot pc", pc, e.pc);
            check_output("slot inst", inst, e.inst);
            check_bit("slot fault", inst_fault, e.fault);
            check_output("slot fetch_cnt", fetch_cnt, e.cnt);
          end
        end
        prev_valid = inst_valid;
        upd_pend   = pc_update && inst_valid;
      end
    end
  endtask

  // One full fetch: wait for the request, optionally stall acceptance, then
  // respond after rsp_wait idle wait cycles.
  task automatic apply_stimulus(input logic [31:0] addr, input logic [31:0] data, input logic err,
                                input int req_wait, input int rsp_wait);
    int n = 0;
    while (!imem_req_valid && n < 8) begin
      step();
      n++;
    end
    check_bit("req_valid asserted", imem_req_valid, 1'b1);
    check_output("req addr", imem_addr, addr);
    for (int i = 0; i < req_wait; i++) begin
      step();
      check_bit("req_valid held while stalled", imem_req_valid, 1'b1);
      check_output("req addr held while stalled", imem_addr, addr);
    end
    if (err) begin
      push_slot(addr, 32'h0, 1'b1, exp_cnt);
    end else begin
      exp_cnt = exp_cnt + 32'd1;
      push_slot(addr, data, 1'b0, exp_cnt);
    end
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    check_bit("req_valid dropped after accept", imem_req_valid, 1'b0);
    for (int i = 0; i < rsp_wait; i++) begin
      step();
      check_bit("inst_valid low while waiting", inst_valid, 1'b0);
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    imem_rsp_err   = err;
    step();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    imem_rsp_err   = 1'b0;
    check_bit("inst_valid one cycle after rsp", inst_valid, 1'b1);
  endtask

  task automatic commit(input logic [31:0] next);
    check_bit("commit from presented slot", inst_valid, 1'b1);
    pc_update = 1'b1;
    pc_next   = next;
    if (next[1:0] != 2'b00) push_slot(next, 32'h0, 1'b1, exp_cnt);
    step();
    pc_update = 1'b0;
    check_output("pc after commit", pc, next);
    if (next[1:0] != 2'b00) begin
      check_bit("misaligned commit faults", inst_fault, 1'b1);
      check_bit("misaligned commit issues no request", imem_req_valid, 1'b0);
    end else begin
      check_bit("inst_valid drops after commit", inst_valid, 1'b0);
      check_bit("inst_fault clear after commit", inst_fault, 1'b0);
    end
  endtask

  // Overall time limit so the bench always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    fork
      monitor();
    join_none

    // Reset values
    repeat (3) step();
    check_output("reset pc", pc, 32'h8000_0000);
    check_bit("reset req_valid", imem_req_valid, 1'b0);
    check_bit("reset inst_valid", inst_valid, 1'b0);
    check_bit("reset inst_fault", inst_fault, 1'b0);
    check_output("reset inst", inst, 32'h0);
    check_output("reset fetch_cnt", fetch_cnt, 32'h0);
    rst = 1'b0;

    // Zero-wait fetch from the reset PC
    apply_stimulus(32'h8000_0000, 32'h0000_0413, 1'b0, 0, 0);

    // Commit to a new PC; a pc_update while requesting is ignored; stalled accept
    commit(32'h8000_0010);
    pc_update = 1'b1;
    pc_next   = 32'h8000_0400;
    step();
    pc_update = 1'b0;
    check_output("pc_update ignored in request", imem_addr, 32'h8000_0010);
    apply_stimulus(32'h8000_0010, 32'h0010_0093, 1'b0, 5, 1);

    // Bus error gives a fault slot; trap redirect refetches
    commit(32'h8000_0014);
    apply_stimulus(32'h8000_0014, 32'hdead_beef, 1'b1, 0, 0);
    commit(32'h8000_0100);
    apply_stimulus(32'h8000_0100, 32'h0000_8067, 1'b0, 0, 2);

    // Misaligned next PC faults without a request
    commit(32'h8000_0002);
    step();
    check_bit("no request while faulted", imem_req_valid, 1'b0);
    check_output("fault pc holds", pc, 32'h8000_0002);

    // Response timeout after three wait cycles
    commit(32'h8000_0200);
    check_bit("timeout req_valid", imem_req_valid, 1'b1);
    push_slot(32'h8000_0200, 32'h0, 1'b1, exp_cnt);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    step();
    step();
    check_bit("still waiting after two cycles", inst_valid, 1'b0);
    step();
    check_bit("timeout fault raised", inst_fault, 1'b1);
    check_output("timeout inst zero", inst, 32'h0);

    // Response outside the wait state is dropped
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0000_1234;
    step();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    check_output("stray rsp leaves inst", inst, 32'h0);
    check_output("stray rsp leaves fetch_cnt", fetch_cnt, exp_cnt);

    // Reset in the middle of a wait; late response ignored
    commit(32'h8000_0204);
    check_bit("req before reset", imem_req_valid, 1'b1);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    step();
    rst = 1'b1;
    #2;
    check_output("async reset pc", pc, 32'h8000_0000);
    check_bit("async reset req_valid", imem_req_valid, 1'b0);
    check_bit("async reset inst_valid", inst_valid, 1'b0);
    check_output("async reset fetch_cnt", fetch_cnt, 32'h0);
    exp_cnt = '0;
    step();
    step();
    rst = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0000_0bad;
    step();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    check_bit("late rsp ignored", inst_valid, 1'b0);
    check_output("late rsp not counted", fetch_cnt, 32'h0);
    apply_stimulus(32'h8000_0000, 32'h0000_0513, 1'b0, 0, 0);

    step();
    step();
    check_output("scoreboard drained", exp_q.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
